// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite protocol constants and byte-lane decode shared by the SRAM slave.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY = 1'b0;

  // Little-endian byte lanes; misaligned low address bits are ignored and any
  // size wider than a word is treated as a full word.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE:  be = 4'b0001 << addr_lo;
      HSIZE_HWORD: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD:  be = 4'b1111;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port SRAM, Depth x 32, per-byte write enables, synchronous read with
// one cycle of latency. Memory contents are not reset; only the read register is.
//   clk   in  clock
//   rst   in  async active-high reset of the read data register
//   re    in  read strobe; rdata updates at the edge, otherwise holds
//   we    in  per-byte write enables
//   addr  in  word address
//   wdata in  write data
//   rdata out registered read data
module sram_1rw #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [3:0]       we,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb3lite_sram_1rw.sv
// AHB3-Lite slave around a single-port SRAM. Zero wait states, always OKAY.
//   HCLK      in  bus clock
//   HRESETn   in  async reset, active-high
//   HSEL      in  slave select from the decoder
//   HADDR     in  byte address (address phase)
//   HWDATA    in  write data (data phase)
//   HRDATA    out read data (data phase), holds between reads
//   HWRITE    in  1=write
//   HSIZE     in  transfer size
//   HBURST    in  ignored
//   HPROT     in  ignored
//   HTRANS    in  transfer type
//   HREADYOUT out constant 1
//   HREADY    in  bus-level ready
//   HRESP     out constant OKAY
module ahb3lite_sram_1rw
  import ahb3lite_pkg::*;
#(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP
);

  localparam int unsigned AddrW = $clog2(MEM_DEPTH);

  logic             accept, rd_acc, wdata_arrive;
  logic [AddrW-1:0] haddr_word;
  logic [3:0]       haddr_be;

  // Write data phase pending
  logic             wph_q;
  logic [AddrW-1:0] wph_addr_q;
  logic [3:0]       wph_be_q;

  // Write buffer, holds write data that lost the SRAM port to a read
  logic                  buf_valid_q, buf_valid_d;
  logic [AddrW-1:0]      buf_addr_q, buf_addr_d;
  logic [3:0]            buf_be_q, buf_be_d;
  logic [HDATA_SIZE-1:0] buf_data_q, buf_data_d;

  // Bytes to overlay on the SRAM read data, frozen at read acceptance
  logic [3:0]            fwd_be_q, fwd_be_d;
  logic [HDATA_SIZE-1:0] fwd_data_q, fwd_data_d;

  logic                  sram_re;
  logic [3:0]            sram_we;
  logic [AddrW-1:0]      sram_addr;
  logic [HDATA_SIZE-1:0] sram_wdata, sram_rdata;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:AddrW+2]};

  assign accept       = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign rd_acc       = accept & ~HWRITE;
  assign wdata_arrive = HREADY & wph_q;
  assign haddr_word   = HADDR[AddrW+1:2];
  assign haddr_be     = ahb_byte_en(HSIZE, HADDR[1:0]);

  // Port arbitration: a new read wins; otherwise drain the buffer, otherwise
  // write the arriving data straight through. Write data can only arrive while
  // the buffer is still full if a read also takes the port in the same edge,
  // which cannot happen (the previous edge accepted a write, so it drained).
  always_comb begin
    sram_re     = 1'b0;
    sram_we     = 4'b0000;
    sram_addr   = haddr_word;
    sram_wdata  = HWDATA;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_be_d    = buf_be_q;
    buf_data_d  = buf_data_q;
    fwd_be_d    = fwd_be_q;
    fwd_data_d  = fwd_data_q;

    if (rd_acc) begin
      sram_re = 1'b1;
    end else if (buf_valid_q) begin
      sram_we     = buf_be_q;
      sram_addr   = buf_addr_q;
      sram_wdata  = buf_data_q;
      buf_valid_d = 1'b0;
    end else if (wdata_arrive) begin
      sram_we   = wph_be_q;
      sram_addr = wph_addr_q;
    end

    if (wdata_arrive && (rd_acc || buf_valid_q)) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wph_addr_q;
      buf_be_d    = wph_be_q;
      buf_data_d  = HWDATA;
    end

    // Anything still buffered after this edge is newer than what the SRAM returns
    if (rd_acc) begin
      fwd_be_d   = (buf_valid_d && (buf_addr_d == haddr_word)) ? buf_be_d : 4'b0000;
      fwd_data_d = buf_data_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      wph_q       <= 1'b0;
      wph_addr_q  <= '0;
      wph_be_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_be_q    <= '0;
      buf_data_q  <= '0;
      fwd_be_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      if (HREADY) begin
        wph_q      <= accept & HWRITE;
        wph_addr_q <= haddr_word;
        wph_be_q   <= haddr_be;
      end
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
      fwd_be_q    <= fwd_be_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  sram_1rw #(
    .Depth (MEM_DEPTH),
    .AddrW (AddrW)
  ) u_sram (
    .clk   (HCLK),
    .rst   (HRESETn),
    .re    (sram_re),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    HRDATA = sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_be_q[i]) begin
        HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = HRESP_OKAY;

endmodule

// File: tb/tb_ahb3lite_sram_1rw.sv
module tb_ahb3lite_sram_1rw;
  import ahb3lite_pkg::*;

  localparam int unsigned Depth = 256;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  ahb3lite_sram_1rw #(
    .HADDR_SIZE (32),
    .HDATA_SIZE (32),
    .MEM_DEPTH  (Depth)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HREADYOUT (HREADYOUT),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Byte-addressed memory model plus the one outstanding write data phase
  logic [7:0]  mdl [0:4*Depth-1];
  logic        pend_wr = 1'b0;
  logic [31:0] pend_addr = '0, pend_wdata = '0;
  logic [2:0]  pend_size = '0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned word_base(input logic [31:0] a);
    return ((a >> 2) % Depth) * 4;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] wd);
    int unsigned n, lo, lane;
    n  = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    lo = a[1:0] - (a[1:0] % n);
    for (int unsigned k = 0; k < n; k++) begin
      lane = lo + k;
      mdl[word_base(a) + lane] = wd[8*lane +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    for (int unsigned lane = 0; lane < 4; lane++) r[8*lane +: 8] = mdl[word_base(a) + lane];
    return r;
  endfunction

  // One bus cycle: drive address phase of this transfer and data of the previous one.
  task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd,
                     input logic rdy);
    logic        rd;
    logic [31:0] rexp;
    HSEL   = sel;   HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
    HREADY = rdy;   HWDATA = pend_wdata;
    HPROT  = 4'($urandom); HBURST = 3'($urandom);
    rd   = 1'b0;
    rexp = '0;
    if (rdy) begin
      if (pend_wr) model_write(pend_addr, pend_size, pend_wdata);
      pend_wr = 1'b0;
      if (sel && trans[1] && wr) begin
        pend_wr = 1'b1; pend_addr = addr; pend_size = size; pend_wdata = wd;
      end
      if (sel && trans[1] && !wr) begin
        rd = 1'b1; rexp = model_read(addr);
      end
    end
    @(posedge HCLK);
    #1;
    if (rd) exp_rdata = rexp;
  endtask

  task automatic wr_t(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, s, a, d, 1'b1);
  endtask

  task automatic rd_t(input logic [31:0] a);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a, 32'h0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic pin(input string name, input logic [31:0] lit);
    @(negedge HCLK);
    chk(name, HRDATA, lit);
    chk({name, "_model"}, exp_rdata, lit);
  endtask

  always @(negedge HCLK) begin
    if (chk_en && !HRESETn) begin
      chk("hreadyout", {31'b0, HREADYOUT}, 32'd1);
      chk("hresp", {31'b0, HRESP}, {31'b0, HRESP_OKAY});
      chk("hrdata", HRDATA, exp_rdata);
    end
  end

  initial begin
    HRESETn = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    HADDR = '0; HWDATA = '0; HREADY = 1'b1; HPROT = '0; HBURST = '0;
    #3;
    chk("reset_hrdata", HRDATA, 32'h0);
    chk("reset_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("reset_hresp", {31'b0, HRESP}, 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    chk_en  = 1'b1;

    // IDLE/BUSY must not write
    wr_t(32'h10, HSIZE_WORD, 32'hCAFEF00D);
    cyc(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h10, 32'h11111111, 1'b1);
    cyc(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10, 32'h22222222, 1'b1);
    idle();
    rd_t(32'h10);
    idle();
    pin("idle_busy_no_write", 32'hCAFEF00D);

    // Word write then back-to-back read (forwarded)
    wr_t(32'h04, HSIZE_WORD, 32'hDEADBEEF);
    rd_t(32'h04);
    idle();
    pin("word_raw", 32'hDEADBEEF);

    // Byte lanes
    wr_t(32'h20, HSIZE_BYTE, 32'h00000011);
    cyc(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'h00002200, 1'b1);
    cyc(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h22, 32'h00330000, 1'b1);
    cyc(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h23, 32'h44000000, 1'b1);
    rd_t(32'h20);
    idle();
    pin("bytes", 32'h44332211);

    // Halfword lanes
    wr_t(32'h30, HSIZE_HWORD, 32'h0000AAAA);
    cyc(1'b1, HTRANS_SEQ, 1'b1, HSIZE_HWORD, 32'h32, 32'h55550000, 1'b1);
    rd_t(32'h30);
    idle();
    pin("halfwords", 32'h5555AAAA);

    // Not selected
    cyc(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h04, 32'hFFFFFFFF, 1'b1);
    idle();
    rd_t(32'h04);
    idle();
    pin("hsel_low", 32'hDEADBEEF);

    // Address wrap
    wr_t(32'h400, HSIZE_WORD, 32'h12345678);
    idle();
    rd_t(32'h0);
    idle();
    pin("wrap", 32'h12345678);

    // Write, write, read, read: second write data lands while a read holds the port
    wr_t(32'h50, HSIZE_WORD, 32'h01020304);
    wr_t(32'h54, HSIZE_WORD, 32'h0A0B0C0D);
    rd_t(32'h50);
    rd_t(32'h54);
    idle();
    pin("wwrr", 32'h0A0B0C0D);

    // HREADY stalls in a write data phase and in a read data phase
    wr_t(32'h60, HSIZE_WORD, 32'h77777777);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'h0, 1'b0);
    rd_t(32'h60);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'h0, 1'b0);
    idle();
    pin("stall", 32'h77777777);

    // Misaligned word, oversize transfer
    wr_t(32'h66, HSIZE_WORD, 32'hA5A5C3C3);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 32'h65, 32'h0, 1'b1);
    idle();
    pin("misaligned", 32'hA5A5C3C3);
    wr_t(32'h68, 3'd3, 32'h0BADCAFE);
    rd_t(32'h68);
    idle();
    pin("size_gt_word", 32'h0BADCAFE);

    // Reset in the middle of a write data phase discards it
    wr_t(32'h40, HSIZE_WORD, 32'h13572468);
    idle();
    wr_t(32'h40, HSIZE_WORD, 32'hBBBBBBBB);
    HRESETn = 1'b1;
    #2;
    chk("mid_reset_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b0;
    pend_wr   = 1'b0;
    exp_rdata = 32'h0;
    idle();
    rd_t(32'h40);
    idle();
    pin("mid_reset_discard", 32'h13572468);

    // Randomised traffic over a fully initialised window of 16 words
    for (int i = 0; i < 16; i++) wr_t(32'(i * 4), HSIZE_WORD, $urandom);
    idle();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {20'($urandom_range(0, 3)) << 2, 6'($urandom), 2'($urandom)} ;
      a = (a & 32'h3F) | (32'($urandom_range(0, 3)) << 10);
      cyc(($urandom_range(0, 9) != 0), 2'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
          a, $urandom, ($urandom_range(0, 9) != 0));
    end
    idle();
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
